// File: rtl/window_scan_ctrl_pkg.sv
// Shared definitions for the window scan sequencer: sizing defaults, timing
// constants and the one-hot state encoding.
package window_scan_ctrl_pkg;

    localparam int unsigned NUM_CH_DEF      = 600;
    localparam int unsigned ADDR_W_DEF      = 10;
    localparam int unsigned SUM_W_DEF       = 8;
    localparam int unsigned INIT_CYCLES_DEF = 600;
    localparam int unsigned TIMEOUT_DEF     = 15;
    // FETCH + LATCH + START + 6 WAIT + REPORT against the nominal accumulator
    localparam int unsigned CH_LATENCY      = 10;

    typedef enum logic [6:0] {
        ST_INIT   = 7'b000_0001,
        ST_IDLE   = 7'b000_0010,
        ST_FETCH  = 7'b000_0100,
        ST_LATCH  = 7'b000_1000,
        ST_START  = 7'b001_0000,
        ST_WAIT   = 7'b010_0000,
        ST_REPORT = 7'b100_0000
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/window_scan_ctrl_if.sv
// Bundle of the sequencer's frame control, sample buffer, accumulator and
// result signals. master = sequencer side, slave = surrounding logic.
interface window_scan_ctrl_if
    import window_scan_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned SUM_W  = SUM_W_DEF
);
    logic              frame_start;
    logic [SUM_W-1:0]  threshold;
    logic              smp_rden;
    logic [ADDR_W-1:0] smp_addr;
    logic              smp_data;
    logic              sw_start;
    logic [ADDR_W-1:0] sw_addr;
    logic              sw_bits;
    logic              sw_done;
    logic [SUM_W-1:0]  sw_sum;
    logic              res_valid;
    logic [ADDR_W-1:0] res_addr;
    logic [SUM_W-1:0]  res_sum;
    logic              res_hit;
    logic [ADDR_W-1:0] hit_count;
    logic              frame_done;
    logic              timeout_err;
    logic              ready;
    logic              busy;

    modport master (
        input  frame_start, threshold, smp_data, sw_done, sw_sum,
        output smp_rden, smp_addr, sw_start, sw_addr, sw_bits,
               res_valid, res_addr, res_sum, res_hit, hit_count,
               frame_done, timeout_err, ready, busy
    );

    modport slave (
        output frame_start, threshold, smp_data, sw_done, sw_sum,
        input  smp_rden, smp_addr, sw_start, sw_addr, sw_bits,
               res_valid, res_addr, res_sum, res_hit, hit_count,
               frame_done, timeout_err, ready, busy
    );

endinterface

// File: rtl/window_scan_timer.sv
// Loadable down-counter with an expiry flag; shared between the power-up
// clear wait and the accumulator done timeout.
module window_scan_timer #(
    parameter int unsigned     W         = 10,
    parameter logic [W-1:0]    RESET_VAL = '0
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/window_scan_ctrl.sv
// Frame scan sequencer: per channel fetch one sample bit, run one accumulator
// update, and report the window sum with a threshold-hit flag.
module window_scan_ctrl
    import window_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH      = NUM_CH_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned SUM_W       = SUM_W_DEF,
    parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
    input logic                clk_i,
    input logic                reset_i,
    window_scan_ctrl_if.master bus
);

    localparam int unsigned       TMR_W    = $clog2(max_u(INIT_CYCLES, TIMEOUT) + 1);
    localparam logic [ADDR_W-1:0] LAST_CH  = ADDR_W'(NUM_CH - 1);
    localparam logic [ADDR_W-1:0] MAX_HITS = ADDR_W'(NUM_CH);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] ch_q;
    logic [SUM_W-1:0]  thr_q;
    logic [SUM_W-1:0]  sum_q;
    logic              hit_q;
    logic              bits_q;
    logic [ADDR_W-1:0] hit_count_q;
    logic              timeout_err_q;

    logic              tmr_load;
    logic              tmr_expired;
    logic              accept;
    logic              capture;
    logic              sum_hit;

    // Reset value covers the post-reset RAM clear; START reloads it for WAIT.
    window_scan_timer #(
        .W         (TMR_W),
        .RESET_VAL (TMR_W'(INIT_CYCLES - 1))
    ) u_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (tmr_load),
        .load_val_i (TMR_W'(TIMEOUT - 1)),
        .expired_o  (tmr_expired)
    );

    assign accept  = (state_q == ST_IDLE) && bus.frame_start;
    assign capture = (state_q == ST_WAIT) && bus.sw_done;
    assign sum_hit = (bus.sw_sum >= thr_q);

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        unique case (state_q)
            ST_INIT:   if (tmr_expired) state_d = ST_IDLE;
            ST_IDLE:   if (bus.frame_start) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_LATCH;
            ST_LATCH:  state_d = ST_START;
            ST_START: begin
                state_d  = ST_WAIT;
                tmr_load = 1'b1;
            end
            ST_WAIT: begin
                if (bus.sw_done) begin
                    state_d = ST_REPORT;
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REPORT: state_d = (ch_q == LAST_CH) ? ST_IDLE : ST_FETCH;
            default:   state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ch_q          <= '0;
            thr_q         <= '0;
            sum_q         <= '0;
            hit_q         <= 1'b0;
            bits_q        <= 1'b0;
            hit_count_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= (state_q == ST_WAIT) && !bus.sw_done && tmr_expired;
            if (accept) begin
                ch_q        <= '0;
                hit_count_q <= '0;
                thr_q       <= bus.threshold;
            end
            if (state_q == ST_LATCH) begin
                bits_q <= bus.smp_data;
            end
            // hit_count already includes the channel shown during REPORT
            if (capture) begin
                sum_q <= bus.sw_sum;
                hit_q <= sum_hit;
                if (sum_hit && hit_count_q != MAX_HITS) begin
                    hit_count_q <= hit_count_q + 1'b1;
                end
            end
            if (state_q == ST_REPORT && ch_q != LAST_CH) begin
                ch_q <= ch_q + 1'b1;
            end
        end
    end

    assign bus.smp_rden    = (state_q == ST_FETCH);
    assign bus.smp_addr    = ch_q;
    assign bus.sw_start    = (state_q == ST_START);
    assign bus.sw_addr     = ch_q;
    assign bus.sw_bits     = bits_q;
    assign bus.res_valid   = (state_q == ST_REPORT);
    assign bus.res_addr    = ch_q;
    assign bus.res_sum     = sum_q;
    assign bus.res_hit     = hit_q;
    assign bus.hit_count   = hit_count_q;
    assign bus.frame_done  = (state_q == ST_REPORT) && (ch_q == LAST_CH);
    assign bus.timeout_err = timeout_err_q;
    assign bus.ready       = (state_q == ST_IDLE);
    assign bus.busy        = (state_q == ST_FETCH) || (state_q == ST_LATCH) ||
                             (state_q == ST_START) || (state_q == ST_WAIT)  ||
                             (state_q == ST_REPORT);

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl with sample-buffer and accumulator
// models and a result scoreboard.
module tb_window_scan_ctrl;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] sum;
        logic       hit;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   t_start = 0;
    int   exp_hits = 0;
    int   fd_cnt = 0;
    int   fd_before;

    exp_t sb_q[$];

    logic       smp_bit = 1'b0;
    logic       smp_rd_seen;
    logic [9:0] smp_ad_seen;
    logic       acc_done = 1'b0;
    logic [7:0] acc_sum = 8'd0;
    logic [9:0] acc_addr;
    logic       stray_done = 1'b0;
    logic       sum_mode = 1'b0;
    logic       withhold_en = 1'b0;
    logic [9:0] withhold_ch = 10'd5;

    window_scan_ctrl_if #(.ADDR_W(10), .SUM_W(8)) bus ();

    window_scan_ctrl #(
        .NUM_CH      (600),
        .ADDR_W      (10),
        .SUM_W       (8),
        .INIT_CYCLES (600),
        .TIMEOUT     (15)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.smp_data = smp_bit;
    assign bus.sw_done  = acc_done | stray_done;
    assign bus.sw_sum   = stray_done ? 8'hFF : acc_sum;

    function automatic logic bitf(input logic [9:0] a);
        return a[0] ^ a[3] ^ a[7];
    endfunction

    function automatic logic [63:0] outs();
        return 64'({bus.ready, bus.busy, bus.smp_rden, bus.smp_addr, bus.sw_start,
                    bus.sw_addr, bus.sw_bits, bus.res_valid, bus.res_addr, bus.res_sum,
                    bus.res_hit, bus.hit_count, bus.frame_done, bus.timeout_err});
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] thr, input int last);
        exp_t e;
        exp_hits = 0;
        for (int k = 0; k <= last; k++) begin
            e.addr = 10'(k);
            e.sum  = sum_mode ? 8'd0 : 8'(k % 64);
            e.hit  = (e.sum >= thr);
            if (e.hit) exp_hits++;
            sb_q.push_back(e);
        end
        bus.threshold   = thr;
        bus.frame_start = 1'b1;
        t_start = cyc;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_frame_done();
        while (!bus.frame_done && (cyc - t_start) < 7000) tick();
        check("frame_latency", 64'(cyc - t_start), 64'd6000);
    endtask

    // Sample buffer: data appears the cycle after the read strobe.
    always begin
        @(negedge clk);
        smp_rd_seen = bus.smp_rden;
        smp_ad_seen = bus.smp_addr;
        @(posedge clk);
        #1;
        smp_bit = smp_rd_seen ? bitf(smp_ad_seen) : 1'b0;
    end

    // Accumulator: done pulse six cycles after the start cycle.
    always begin
        @(negedge clk);
        if (!reset && bus.sw_start) begin
            acc_addr = bus.sw_addr;
            check("sw_bits", 64'(bus.sw_bits), 64'(bitf(acc_addr)));
            if (!(withhold_en && acc_addr == withhold_ch)) begin
                repeat (6) @(posedge clk);
                #1;
                acc_done = 1'b1;
                acc_sum  = sum_mode ? 8'd0 : 8'(acc_addr[5:0]);
                @(posedge clk);
                #1;
                acc_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.res_valid) begin
                exp_t e;
                check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("res_addr", 64'(bus.res_addr), 64'(e.addr));
                    check("res_sum", 64'(bus.res_sum), 64'(e.sum));
                    check("res_hit", 64'(bus.res_hit), 64'(e.hit));
                end
            end
            if (bus.frame_done) begin
                fd_cnt++;
                check("frame_done_last", 64'({bus.res_valid, bus.res_addr}), 64'({1'b1, 10'd599}));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.frame_start = 1'b0;
        bus.threshold   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 64'd0);
        reset = 1'b0;

        // frame_start during INIT is dropped
        repeat (100) tick();
        check("init_ready_c100", 64'(bus.ready), 64'd0);
        bus.threshold   = 8'd32;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("init_start_ignored", 64'({bus.busy, bus.ready}), 64'd0);
        repeat (498) tick();
        check("init_ready_c599", 64'(bus.ready), 64'd0);
        tick();
        check("init_ready_c600", 64'(bus.ready), 64'd1);

        // Frame 1: sum = ch[5:0], threshold 32
        sum_mode = 1'b0;
        start_frame(8'd32, 599);
        check("f1_busy", 64'({bus.busy, bus.ready}), 64'b10);
        check("f1_fetch0", 64'({bus.smp_rden, bus.smp_addr}), 64'({1'b1, 10'd0}));
        tick();
        check("f1_sw_start_c2", 64'(bus.sw_start), 64'd0);
        tick();
        check("f1_sw_start_c3", 64'({bus.sw_start, bus.sw_addr}), 64'({1'b1, 10'd0}));
        wait_frame_done();
        check("f1_hit_count", 64'(bus.hit_count), 64'(exp_hits));
        check("f1_hit_count_288", 64'(exp_hits), 64'(bus.hit_count == 10'd288 ? exp_hits : -1));
        tick();
        check("f1_idle", 64'({bus.ready, bus.busy}), 64'b10);
        check("f1_sb_empty", 64'(sb_q.size()), 64'd0);

        // Frame 2: threshold 0, all sums 0
        sum_mode = 1'b1;
        start_frame(8'd0, 599);
        check("f2_busy", 64'(bus.busy), 64'd1);
        wait_frame_done();
        check("f2_hit_count", 64'(bus.hit_count), 64'd600);
        tick();
        check("f2_sb_empty", 64'(sb_q.size()), 64'd0);

        // Frame 3: ch 5 never completes
        sum_mode    = 1'b0;
        withhold_en = 1'b1;
        fd_before   = fd_cnt;
        start_frame(8'd32, 4);
        while (!bus.timeout_err && (cyc - t_start) < 200) tick();
        check("f3_timeout_latency", 64'(cyc - t_start), 64'd69);
        check("f3_idle", 64'({bus.ready, bus.busy}), 64'b10);
        check("f3_no_frame_done", 64'(fd_cnt), 64'(fd_before));
        check("f3_sb_empty", 64'(sb_q.size()), 64'd0);
        withhold_en = 1'b0;
        tick();
        check("f3_timeout_pulse", 64'(bus.timeout_err), 64'd0);

        // Frame 4: stray sw_done in FETCH, frame_start while busy
        start_frame(8'd32, 599);
        while (!(bus.smp_rden && bus.smp_addr == 10'd10) && (cyc - t_start) < 500) tick();
        check("f4_fetch10", 64'({bus.smp_rden, bus.smp_addr}), 64'({1'b1, 10'd10}));
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        bus.threshold = 8'd0;
        for (int i = 0; i < 3; i++) begin
            bus.frame_start = 1'b1;
            tick();
            bus.frame_start = 1'b0;
            repeat (7) tick();
        end
        wait_frame_done();
        check("f4_hit_count", 64'(bus.hit_count), 64'(exp_hits));
        tick();
        check("f4_sb_empty", 64'(sb_q.size()), 64'd0);

        // Frame 5: reset at ch 300, then full INIT and a fresh frame
        bus.threshold = 8'd32;
        start_frame(8'd32, 599);
        while (!(bus.smp_rden && bus.smp_addr == 10'd300) && (cyc - t_start) < 4000) tick();
        check("f5_fetch300", 64'({bus.smp_rden, bus.smp_addr}), 64'({1'b1, 10'd300}));
        reset = 1'b1;
        #1;
        check("f5_reset_outputs", outs(), 64'd0);
        sb_q.delete();
        tick();
        tick();
        check("f5_reset_hold", outs(), 64'd0);
        reset = 1'b0;
        repeat (599) tick();
        check("f5_ready_c599", 64'(bus.ready), 64'd0);
        tick();
        check("f5_ready_c600", 64'(bus.ready), 64'd1);
        start_frame(8'd32, 599);
        check("f5_fetch0", 64'({bus.smp_rden, bus.smp_addr}), 64'({1'b1, 10'd0}));
        wait_frame_done();
        check("f5_hit_count", 64'(bus.hit_count), 64'(exp_hits));
        tick();
        check("f5_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
